mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory-stage access controller sitting directly downstream of the execute stage. It consumes the ALU result as a byte address and the store data (read2data), and drives the data cache's Rd/Wr request interface. It holds each request stable until the cache signals completion, stalling the pipeline in the meantime. It returns load data, detects misaligned, illegal and timed-out accesses, and keeps saturating load/store counters.

## Interface
- TIMEOUT, 64: number of BUSY cycles without cache_Done before a timeout error is raised.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- MemRead  in  1  load request from the EX/MEM stage.
- MemWrite  in  1  store request from the EX/MEM stage.
- ALU_res  in  16  byte address produced by execute.
- write_data  in  16  store data (execute read2data).
- cache_Addr  out  16  address to the cache.
- cache_DataIn  out  16  store data to the cache.
- cache_Rd  out  1  cache read request.
- cache_Wr  out  1  cache write request.
- cache_DataOut  in  16  read data from the cache; valid when cache_Done is high.
- cache_Done  in  1  one-cycle pulse marking completion of the current request.
- cache_Err  in  1  cache-reported error.
- mem_data  out  16  load result.
- mem_stall  out  1  freezes the upstream pipeline.
- mem_err  out  1  sticky error flag.
- rd_count  out  16  completed loads, saturating.
- wr_count  out  16  completed stores, saturating.

## Operation
- States: IDLE, BUSY, ERR.
- req = MemRead | MemWrite.
- Illegal request: (MemRead & MemWrite), or req & ALU_res[0].

IDLE
- In IDLE, cache_Addr, cache_DataIn, cache_Rd and cache_Wr pass through combinationally from ALU_res, write_data, MemRead and MemWrite.
- Legal req with cache_Done high in the same cycle (hit): the access completes and the FSM stays in IDLE.
- Legal req without cache_Done: the block latches address, data and op, then moves to BUSY.
- Illegal req: cache_Rd and cache_Wr are forced to 0, no request is issued, and the FSM moves to ERR.

BUSY
- Outputs are driven from the latched registers; the inputs are ignored.
- cache_Done: the access completes and the FSM returns to IDLE.
- cache_Err, or the timeout counter reaching TIMEOUT-1 without Done: the FSM moves to ERR.

ERR
- cache_Rd = cache_Wr = 0.
- mem_err = 1 and mem_stall = 1.
- Only rst leaves ERR.

cache_Err while in IDLE with a req: the FSM moves to ERR and the access does not complete.

On completion:
- A load captures cache_DataOut into the data register.
- mem_data = cache_DataOut during the completion cycle; otherwise mem_data holds the data register.
- A store leaves the data register unchanged.
- The matching counter increments by 1 and holds at 16'hFFFF.

mem_stall = (req & ~cache_Done & state==IDLE) | (state==BUSY & ~cache_Done) | (state==ERR).

The timeout counter clears on entry to BUSY and increments each BUSY cycle.

## Timing
- Reset values: state IDLE; all latched registers, mem_data, rd_count, wr_count and the timeout counter 0; mem_err 0.
- Reset while BUSY aborts the request: cache_Rd and cache_Wr drop immediately (asynchronous).
- A hit completes in 0 extra cycles, with no stall.
- A miss completing N cycles after the request stalls for exactly N cycles. mem_stall drops in the cycle cache_Done is high.
- cache_Rd/cache_Wr, cache_Addr and cache_DataIn are stable from the request cycle through the Done cycle.
- Back-to-back requests: a new req may be presented in the cycle after Done; no dead cycle is required.
- cache_Done while idle with no req is ignored; no counter changes.
- A timeout is raised after exactly TIMEOUT BUSY cycles.

## Test plan
- Load hit: MemRead=1, ALU_res=16'h0010, cache_Done=1 in the same cycle with DataOut=16'hBEEF -> mem_stall never high; mem_data=BEEF that cycle and after; rd_count=1.
- Store miss: MemWrite=1, addr 16'h0020, data 16'h1234; inputs change after the first cycle; Done arrives 4 cycles later -> cache_Wr, cache_Addr=0020 and cache_DataIn=1234 held for 5 cycles; mem_stall high for 4; wr_count=1.
- Misaligned load at 16'h0003 -> cache_Rd stays 0; mem_err=1 the next cycle; mem_stall=1 held until rst.
- Timeout with TIMEOUT=64 and no Done -> mem_err asserts after 64 BUSY cycles.
- cache_Err during BUSY -> ERR.
- Saturation: rd_count preloaded by 65535 hits, then one more hit -> stays 16'hFFFF.
- Reset mid-miss: rst asserted while BUSY -> cache_Rd=0 immediately; after release, state IDLE and a new hit completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: drives data cache Rd/Wr requests, holds them
// until cache_Done, stalls the pipeline, and flags misaligned/illegal/timed-out accesses.
module mem_access_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [15:0] ALU_res,
  input  logic [15:0] write_data,
  output logic [15:0] cache_Addr,
  output logic [15:0] cache_DataIn,
  output logic        cache_Rd,
  output logic        cache_Wr,
  input  logic [15:0] cache_DataOut,
  input  logic        cache_Done,
  input  logic        cache_Err,
  output logic [15:0] mem_data,
  output logic        mem_stall,
  output logic        mem_err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  // state  | meaning
  // S_IDLE | inputs pass through to the cache; hits complete here
  // S_BUSY | miss outstanding, cache driven from latched request
  // S_ERR  | sticky error, requests blocked until rst
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERR} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic [15:0] r_addr, r_wdata, r_data, r_tmo, r_rd_cnt, r_wr_cnt;
  logic        r_rd, r_wr;
  logic        w_req, w_illegal, w_latch, w_done_rd, w_done_wr;

  assign w_req     = MemRead | MemWrite;
  assign w_illegal = (MemRead & MemWrite) | (w_req & ALU_res[0]);

  always_comb begin
    w_next       = r_state;
    w_latch      = 1'b0;
    w_done_rd    = 1'b0;
    w_done_wr    = 1'b0;
    cache_Addr   = ALU_res;
    cache_DataIn = write_data;
    cache_Rd     = MemRead;
    cache_Wr     = MemWrite;
    mem_stall    = 1'b0;
    case (r_state)
      S_IDLE: begin
        mem_stall = w_req & ~cache_Done;
        if (w_illegal) begin
          cache_Rd = 1'b0;
          cache_Wr = 1'b0;
          w_next   = S_ERR;
        end else if (w_req) begin
          if (cache_Err) begin
            w_next = S_ERR;
          end else if (cache_Done) begin
            w_done_rd = MemRead;
            w_done_wr = MemWrite;
          end else begin
            w_latch = 1'b1;
            w_next  = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cache_Addr   = r_addr;
        cache_DataIn = r_wdata;
        cache_Rd     = r_rd;
        cache_Wr     = r_wr;
        mem_stall    = ~cache_Done;
        if (cache_Err) begin
          w_next = S_ERR;
        end else if (cache_Done) begin
          w_done_rd = r_rd;
          w_done_wr = r_wr;
          w_next    = S_IDLE;
        end else if (r_tmo == TMO_LAST) begin
          w_next = S_ERR;
        end
      end
      S_ERR: begin
        cache_Rd  = 1'b0;
        cache_Wr  = 1'b0;
        mem_stall = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
    // Reset must abort an outstanding request without waiting for a clock edge.
    if (rst) begin
      cache_Rd = 1'b0;
      cache_Wr = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_data   <= '0;
      r_tmo    <= '0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_addr  <= ALU_res;
        r_wdata <= write_data;
        r_rd    <= MemRead;
        r_wr    <= MemWrite;
      end
      if (w_done_rd) begin
        r_data <= cache_DataOut;
        if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
      end
      if (w_done_wr && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
      if (w_latch)                r_tmo <= '0;
      else if (r_state == S_BUSY) r_tmo <= r_tmo + 16'd1;
    end
  end

  assign mem_data = w_done_rd ? cache_DataOut : r_data;
  assign mem_err  = (r_state == S_ERR);
  assign rd_count = r_rd_cnt;
  assign wr_count = r_wr_cnt;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed corner cases plus random
// load/store transactions checked against a transaction-level model.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite, cache_Done, cache_Err;
  logic [15:0] ALU_res, write_data, cache_DataOut;
  logic [15:0] cache_Addr, cache_DataIn, mem_data, rd_count, wr_count;
  logic        cache_Rd, cache_Wr, mem_stall, mem_err;

  int n_cmp = 0;
  int n_err = 0;

  // transaction-level model: last load data and completed-access counts
  logic [15:0] m_data;
  int          m_rd, m_wr;

  mem_access_ctrl #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALU_res(ALU_res), .write_data(write_data), .cache_Addr(cache_Addr),
    .cache_DataIn(cache_DataIn), .cache_Rd(cache_Rd), .cache_Wr(cache_Wr),
    .cache_DataOut(cache_DataOut), .cache_Done(cache_Done), .cache_Err(cache_Err),
    .mem_data(mem_data), .mem_stall(mem_stall), .mem_err(mem_err),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MemRead = 0; MemWrite = 0; cache_Done = 0; cache_Err = 0;
    ALU_res = '0; write_data = '0; cache_DataOut = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    m_data = '0; m_rd = 0; m_wr = 0;
    tick();
  endtask

  function automatic logic [15:0] sat(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  // One access whose Done arrives n cycles after the request cycle.
  task automatic do_txn(input bit is_ld, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [15:0] rdv, input int n);
    for (int c = 0; c <= n; c++) begin
      if (c == 0) begin
        MemRead = is_ld; MemWrite = !is_ld; ALU_res = addr; write_data = wd;
      end else begin
        MemRead = 1'($urandom); MemWrite = 1'($urandom);
        ALU_res = 16'($urandom); write_data = 16'($urandom);
      end
      cache_Done    = (c == n);
      cache_DataOut = (c == n) ? rdv : 16'($urandom);
      #2;
      chk("addr",  cache_Addr, addr);
      chk("din",   cache_DataIn, wd);
      chk("rd",    16'(cache_Rd), 16'(is_ld));
      chk("wr",    16'(cache_Wr), 16'(!is_ld));
      chk("stall", 16'(mem_stall), 16'(c < n));
      chk("mdata", mem_data, (c == n && is_ld) ? rdv : m_data);
      tick();
    end
    if (is_ld) begin m_data = rdv; m_rd++; end
    else m_wr++;
    idle_inputs();
    #1;
    chk("rd_count", rd_count, sat(m_rd));
    chk("wr_count", wr_count, sat(m_wr));
    chk("err_ok",   16'(mem_err), 16'd0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    m_data = '0; m_rd = 0; m_wr = 0;
    #2;
    chk("rst_rd",    16'(cache_Rd), 16'd0);
    chk("rst_mdata", mem_data, 16'd0);
    chk("rst_rdc",   rd_count, 16'd0);
    chk("rst_wrc",   wr_count, 16'd0);
    chk("rst_err",   16'(mem_err), 16'd0);
    chk("rst_stall", 16'(mem_stall), 16'd0);
    #10;
    rst = 1'b0;
    tick();

    do_txn(1'b1, 16'h0010, 16'h0000, 16'hBEEF, 0);
    chk("hit_hold", mem_data, 16'hBEEF);
    do_txn(1'b0, 16'h0020, 16'h1234, 16'h0000, 4);

    for (int t = 0; t < 150; t++) begin
      int gap;
      do_txn(1'($urandom), {15'($urandom), 1'b0}, 16'($urandom), 16'($urandom),
             $urandom_range(0, 4));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        cache_Done = 1'($urandom);
        cache_DataOut = 16'($urandom);
        #2;
        chk("idle_stall", 16'(mem_stall), 16'd0);
        chk("idle_mdata", mem_data, m_data);
        tick();
        chk("idle_rdc", rd_count, sat(m_rd));
        chk("idle_wrc", wr_count, sat(m_wr));
        idle_inputs();
      end
    end

    // timeout: exactly 64 BUSY cycles without Done
    do_reset();
    MemRead = 1; ALU_res = 16'h0040;
    tick();
    MemRead = 0;
    for (int k = 0; k < 64; k++) begin
      chk("tmo_pre_err", 16'(mem_err), 16'd0);
      chk("tmo_stall",   16'(mem_stall), 16'd1);
      tick();
    end
    chk("tmo_err", 16'(mem_err), 16'd1);
    chk("tmo_rd",  16'(cache_Rd), 16'd0);

    // cache error while BUSY
    do_reset();
    MemWrite = 1; ALU_res = 16'h0042; write_data = 16'h5555;
    tick();
    MemWrite = 0;
    chk("cerr_busy_wr", 16'(cache_Wr), 16'd1);
    cache_Err = 1;
    tick();
    cache_Err = 0;
    chk("cerr_err", 16'(mem_err), 16'd1);
    chk("cerr_wr",  16'(cache_Wr), 16'd0);
    chk("cerr_wrc", wr_count, 16'd0);

    // misaligned load
    do_reset();
    MemRead = 1; ALU_res = 16'h0003;
    #1;
    chk("mis_rd",     16'(cache_Rd), 16'd0);
    chk("mis_err0",   16'(mem_err), 16'd0);
    tick();
    MemRead = 0;
    chk("mis_err1",   16'(mem_err), 16'd1);
    for (int k = 0; k < 3; k++) tick();
    chk("mis_stall",  16'(mem_stall), 16'd1);
    chk("mis_errh",   16'(mem_err), 16'd1);

    // reset mid-miss, then a normal hit
    do_reset();
    MemRead = 1; ALU_res = 16'h0080;
    tick();
    MemRead = 0;
    chk("mid_busy_rd", 16'(cache_Rd), 16'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd", 16'(cache_Rd), 16'd0);
    #2;
    rst = 1'b0;
    m_data = '0; m_rd = 0; m_wr = 0;
    tick();
    chk("mid_stall", 16'(mem_stall), 16'd0);
    do_txn(1'b1, 16'h0090, 16'h0000, 16'hCAFE, 0);

    // rd_count saturation
    do_reset();
    MemRead = 1; ALU_res = 16'h0010; cache_Done = 1; cache_DataOut = 16'h0001;
    for (int k = 0; k < 65535; k++) @(posedge clk);
    #1;
    chk("sat_full", rd_count, 16'hFFFF);
    tick();
    chk("sat_hold", rd_count, 16'hFFFF);
    chk("sat_err",  16'(mem_err), 16'd0);
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
